// File: rtl/bless_inject_ctrl.sv
// Local-port injection controller for the bufferless router.
// PE flits are queued in a small FIFO and presented on router port 4 for a
// single cycle whenever the router reports a free slot. Consecutive blocked
// cycles are counted so the throttling logic can see injection starvation.
module bless_inject_ctrl #(
  parameter int unsigned CTRL_W       = 24,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned VALID_BIT    = 23,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned OCC_W       = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_valid,
  input  logic [CTRL_W-1:0] pe_ctrl,
  input  logic [DATA_W-1:0] pe_data,
  output logic              pe_ready,
  input  logic              port4_ready,
  output logic [CTRL_W-1:0] inj_ctrl,
  output logic [DATA_W-1:0] inj_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic              starved
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);
  localparam logic [OCC_W-1:0] Full  = OCC_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSend, StStall, StStarved} state_e;

  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] inj_ctrl_q;
  logic [DATA_W-1:0] inj_data_q;
  logic [CTRL_W-1:0] head_ctrl;
  state_e            state_q, state_d;

  logic empty, full, push_stored, pop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == Full);

  // Held low during reset so nothing is accepted while state is being cleared.
  assign pe_ready    = rst & ~full;
  // Flits with the valid bit clear are handshaken but never stored.
  assign push_stored = pe_valid & pe_ready & pe_ctrl[VALID_BIT];
  // Pop decision uses pre-edge occupancy: a flit pushed this edge cannot leave on it.
  assign pop         = ~empty & port4_ready;

  assign occupancy = occ_q;
  assign inj_ctrl  = inj_ctrl_q;
  assign inj_data  = inj_data_q;
  assign starved   = (state_q == StStarved);

  // Head flit as presented to the router, valid bit forced on.
  always_comb begin
    head_ctrl            = ctrl_mem[rd_ptr_q];
    head_ctrl[VALID_BIT] = 1'b1;
  end

  // Next occupancy, starvation count and post-edge FSM state.
  always_comb begin
    occ_d = occ_q + OCC_W'(push_stored) - OCC_W'(pop);

    cnt_d = '0;
    if (!empty && !port4_ready) begin
      cnt_d = (cnt_q >= Limit) ? Limit : cnt_q + CNT_W'(1);
    end

    state_d = StIdle;
    if (occ_d != '0) begin
      if (cnt_d == Limit)            state_d = StStarved;
      else if (pop || cnt_d == '0)   state_d = StSend;
      else                           state_d = StStall;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_stored) begin
      ctrl_mem[wr_ptr_q] <= pe_ctrl;
      data_mem[wr_ptr_q] <= pe_data;
    end
  end

  // Pointers, occupancy, counter, FSM and the registered injection outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      inj_ctrl_q <= '0;
      inj_data_q <= '0;
      state_q    <= StIdle;
    end else begin
      if (push_stored) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)         rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (pop) begin
        inj_ctrl_q <= head_ctrl;
        inj_data_q <= data_mem[rd_ptr_q];
      end else begin
        inj_ctrl_q <= '0;
        inj_data_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Directed, table-driven bench for bless_inject_ctrl (default parameters).
module tb_bless_inject_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pe_valid = 1'b0;
  logic [23:0] pe_ctrl = '0;
  logic [31:0] pe_data = '0;
  logic        pe_ready;
  logic        port4_ready = 1'b0;
  logic [23:0] inj_ctrl;
  logic [31:0] inj_data;
  logic [2:0]  occupancy;
  logic        starved;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bless_inject_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pe_valid    (pe_valid),
    .pe_ctrl     (pe_ctrl),
    .pe_data     (pe_data),
    .pe_ready    (pe_ready),
    .port4_ready (port4_ready),
    .inj_ctrl    (inj_ctrl),
    .inj_data    (inj_data),
    .occupancy   (occupancy),
    .starved     (starved)
  );

  typedef struct {
    logic        pv;
    logic [23:0] ctrl;
    logic [31:0] data;
    logic        p4r;
    logic        e_rdy;
    logic [23:0] e_ctrl;
    logic [31:0] e_data;
    logic [2:0]  e_occ;
    logic        e_stv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic pv, logic [23:0] ctrl, logic [31:0] data, logic p4r,
                              logic e_rdy, logic [23:0] e_ctrl, logic [31:0] e_data,
                              logic [2:0] e_occ, logic e_stv);
    vec_t v;
    v.pv = pv; v.ctrl = ctrl; v.data = data; v.p4r = p4r;
    v.e_rdy = e_rdy; v.e_ctrl = e_ctrl; v.e_data = e_data; v.e_occ = e_occ; v.e_stv = e_stv;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic e_rdy, logic [23:0] e_ctrl, logic [31:0] e_data,
                       logic [2:0] e_occ, logic e_stv);
    nvec++;
    if (pe_ready !== e_rdy || inj_ctrl !== e_ctrl || inj_data !== e_data ||
        occupancy !== e_occ || starved !== e_stv) begin
      nerr++;
      $display("FAIL %s: got rdy=%b ctrl=%h data=%h occ=%0d stv=%b, want rdy=%b ctrl=%h data=%h occ=%0d stv=%b",
               name, pe_ready, inj_ctrl, inj_data, occupancy, starved,
               e_rdy, e_ctrl, e_data, e_occ, e_stv);
    end
  endtask

  initial begin
    // Basic inject
    add(1, 24'h800011, 32'hDEADBEEF, 1, 1, 24'h0,      32'h0,        1, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h800011, 32'hDEADBEEF, 0, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h0,      32'h0,        0, 0);
    // Invalid PE flits: handshaken, not stored
    add(1, 24'h000055, 32'h1234,     1, 1, 24'h0,      32'h0,        0, 0);
    add(1, 24'h000077, 32'h5678,     0, 1, 24'h0,      32'h0,        0, 0);
    // Fill to full with router blocked; fifth push is refused
    add(1, 24'h800001, 32'hA1,       0, 1, 24'h0,      32'h0,        1, 0);
    add(1, 24'h800002, 32'hA2,       0, 1, 24'h0,      32'h0,        2, 0);
    add(1, 24'h800003, 32'hA3,       0, 1, 24'h0,      32'h0,        3, 0);
    add(1, 24'h800004, 32'hA4,       0, 0, 24'h0,      32'h0,        4, 0);
    add(1, 24'h800005, 32'hA5,       0, 0, 24'h0,      32'h0,        4, 0);
    // Drain in push order
    add(0, 24'h0,      32'h0,        1, 1, 24'h800001, 32'hA1,       3, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h800002, 32'hA2,       2, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h800003, 32'hA3,       1, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h800004, 32'hA4,       0, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h0,      32'h0,        0, 0);
    // Starvation: one flit, 9 blocked edges (asserts on the 8th, saturates)
    add(1, 24'h800033, 32'h33,       0, 1, 24'h0,      32'h0,        1, 0);
    for (int i = 1; i <= 9; i++) begin
      add(0, 24'h0, 32'h0, 0, 1, 24'h0, 32'h0, 1, (i >= 8) ? 1'b1 : 1'b0);
    end
    add(0, 24'h0,      32'h0,        1, 1, 24'h800033, 32'h33,       0, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h0,      32'h0,        0, 0);
    // Simultaneous push/pop at occupancy 2
    add(1, 24'h800041, 32'hB1,       0, 1, 24'h0,      32'h0,        1, 0);
    add(1, 24'h800042, 32'hB2,       0, 1, 24'h0,      32'h0,        2, 0);
    add(1, 24'h800043, 32'hB3,       1, 1, 24'h800041, 32'hB1,       2, 0);
    add(1, 24'h800044, 32'hB4,       1, 1, 24'h800042, 32'hB2,       2, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h800043, 32'hB3,       1, 0);
    add(0, 24'h0,      32'h0,        1, 1, 24'h800044, 32'hB4,       0, 0);

    // Reset held with PE offering a flit
    pe_valid = 1'b1; pe_ctrl = 24'h8000AA; pe_data = 32'hAA; port4_ready = 1'b1;
    step();
    check("reset_hold0", 0, 24'h0, 32'h0, 0, 0);
    step();
    check("reset_hold1", 0, 24'h0, 32'h0, 0, 0);
    pe_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_release", 1, 24'h0, 32'h0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      pe_valid = vecs[i].pv; pe_ctrl = vecs[i].ctrl; pe_data = vecs[i].data;
      port4_ready = vecs[i].p4r;
      step();
      check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_ctrl, vecs[i].e_data,
            vecs[i].e_occ, vecs[i].e_stv);
    end

    // Streaming 10 flits with router always ready: pointers wrap, order kept
    port4_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [23:0] ec;
      logic [31:0] ed;
      pe_valid = (i < 10);
      pe_ctrl  = 24'h800100 + 24'(i);
      pe_data  = 32'hC000 + 32'(i);
      step();
      ec = (i >= 1 && i <= 10) ? 24'h800100 + 24'(i - 1) : 24'h0;
      ed = (i >= 1 && i <= 10) ? 32'hC000 + 32'(i - 1) : 32'h0;
      check($sformatf("stream%0d", i), 1, ec, ed, (i < 10) ? 3'd1 : 3'd0, 0);
    end

    // Asynchronous reset mid-stream with flits queued and one on the output
    port4_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pe_valid = 1'b1; pe_ctrl = 24'h800200 + 24'(i); pe_data = 32'hD0 + 32'(i);
      step();
    end
    check("mid_queued", 1, 24'h0, 32'h0, 3, 0);
    pe_valid = 1'b0; port4_ready = 1'b1;
    step();
    check("mid_pop", 1, 24'h800200, 32'hD0, 2, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_reset", 0, 24'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_release", 1, 24'h0, 32'h0, 0, 0);
    step();
    check("mid_discard", 1, 24'h0, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bless_inject_ctrl.md
Name: bless_inject_ctrl

Overview:
Local-port injection controller for the bufferless (BLESS) router. It queues flits from the processing element (PE) in a small FIFO. It drives the router's port 4 control/data inputs only when the router reports a free output slot on port4_ready. It tracks consecutive blocked cycles and flags injection starvation to the throttling logic.

Parameters:
CTRL_W, 24, width of a flit control word (matches router control width)
DATA_W, 32, width of a flit data word (matches router data width)
VALID_BIT, 23, bit index of the valid flag within the control word
DEPTH, 4, injection FIFO entries; power of two, >= 2
STARVE_LIMIT, 8, consecutive blocked cycles before starved asserts; 1..2^CNT_W-1
CNT_W, 4, width of the starvation counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
pe_valid  in  1  PE offers a flit this cycle
pe_ctrl  in  CTRL_W  PE flit control word
pe_data  in  DATA_W  PE flit data word
pe_ready  out  1  controller can accept a flit this cycle
port4_ready  in  1  router can accept an injected flit next cycle
inj_ctrl  out  CTRL_W  registered control word to router port 4
inj_data  out  DATA_W  registered data word to router port 4
occupancy  out  log2(DEPTH)+1  current FIFO entry count
starved  out  1  injection is starved (registered)

Behaviour:
- Reset (rst=0, async): FIFO empty, read/write pointers 0, occupancy 0, inj_ctrl 0, inj_data 0, starved 0, counter 0, FSM in IDLE, pe_ready 0 while rst=0. On deassertion, pe_ready = 1 from the first active cycle. Flits held at reset are discarded.
- pe_ready = ~full (full: occupancy == DEPTH). No bypass: pe_ready does not depend on port4_ready.
- Push: pe_valid & pe_ready at a clock edge.
  - If pe_ctrl[VALID_BIT] = 1, the flit is written at the write pointer and the pointer increments mod DEPTH.
  - If pe_ctrl[VALID_BIT] = 0, the flit is accepted and discarded, with no FIFO change.
- Pop: at each edge, if the FIFO is non-empty (pre-edge) and port4_ready = 1, the head flit is popped.
  - inj_ctrl <= head ctrl with bit VALID_BIT forced to 1; inj_data <= head data.
  - Otherwise inj_ctrl <= 0 and inj_data <= 0.
  - Each flit is presented for exactly one cycle.
- Simultaneous push and pop in one edge: both occur, occupancy unchanged. A push into an empty FIFO is not popped on the same edge.
- Latency: a flit pushed at edge N is earliest visible on inj_ctrl after edge N+1 (2-edge minimum). Order is strict FIFO.
- Occupancy arithmetic: occ_next = occ + push_stored - pop, in range 0..DEPTH. Pointers wrap mod DEPTH.
- Starvation counter:
  - Blocked cycle: non-empty & ~port4_ready → counter increments, saturating at STARVE_LIMIT.
  - Any pop, or FIFO empty → counter clears to 0.
  - starved <= (counter_next >= STARVE_LIMIT), registered.
- FSM, evaluated on post-edge state:
  - IDLE: FIFO empty.
  - SEND: non-empty, last edge popped or counter 0.
  - STALL: non-empty, 0 < counter < STARVE_LIMIT.
  - STARVED: counter = STARVE_LIMIT; starved = 1.
  - Transitions: IDLE→SEND on a stored push. SEND/STALL/STARVED→IDLE when the last entry pops with no push. STALL/STARVED→SEND on a pop. STALL→STARVED at the limit.
- Reset asserted mid-operation: immediate async clear, as above. A flit on inj_ctrl in that cycle is dropped; the router sees valid 0.

Test Plan:
- Reset: hold rst=0 with pe_valid=1 → pe_ready=0, inj_ctrl=0, occupancy=0, starved=0. Release rst → pe_ready=1 next cycle.
- Basic inject: port4_ready=1; push ctrl 0x800011, data 0xDEADBEEF at edge 0 → after edge 1, inj_ctrl=0x800011 and inj_data=0xDEADBEEF for one cycle, then 0. occupancy returns to 0.
- Fill/full: port4_ready=0; push 5 valid flits back-to-back → 4 accepted, pe_ready=0 after the 4th push, occupancy=4. Raise port4_ready → flits emerge in push order on 4 consecutive cycles.
- Starvation: one flit queued, port4_ready=0 for 8 cycles → starved=1 after the 8th blocked edge, FSM=STARVED. port4_ready=1 → flit injected, starved=0 the same edge, counter 0.
- Simultaneous push/pop at occupancy 2, and wrap-around: stream 10 flits with port4_ready=1 → occupancy steady, pointers wrap, output order preserved, no loss or duplication.
- Invalid PE flit: pe_valid=1 with ctrl valid bit 0 → accepted (pe_ready=1), occupancy unchanged, nothing injected. Assert rst mid-stream with 3 queued → outputs 0 and occupancy 0 immediately.
